// File: rtl/bcd_convert_scheduler_if.sv
// Request/result bundle for the BCD conversion scheduler.
// The master side issues requests and consumes results; the slave side is the scheduler.
interface bcd_convert_scheduler_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [11:0] out_bcd;

  modport master (
    output req, req_data, out_ready,
    input  grant, busy, out_valid, out_id, out_bcd
  );

  modport slave (
    input  req, req_data, out_ready,
    output grant, busy, out_valid, out_id, out_bcd
  );
endinterface

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler feeding one shared 8-bit binary to 3-digit BCD converter.
// A grant starts an 8-step double-dabble; the result is held until the consumer accepts it.
module bcd_convert_scheduler (
  input  logic                      clk,
  input  logic                      rst_n,
  bcd_convert_scheduler_if.slave    bus
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [ID_W-1:0]  last_q,      last_d;
  logic [ID_W-1:0]  id_q,        id_d;
  logic [OP_W-1:0]  op_q,        op_d;
  logic [BCD_W-1:0] dig_q,       dig_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [BCD_W-1:0] out_bcd_q,   out_bcd_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  idx;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] dig_step;
  logic [OP_W-1:0]  op_step;
  logic [N_REQ-1:0] grant_c;

  // Round-robin pick: scan starting just after the last granted requester.
  always_comb begin : arb
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      idx = ID_W'(last_q + ID_W'(i));
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // One double-dabble step on {digits, operand}.
  always_comb begin : dabble
    adj = '0;
    for (int d = 0; d < 3; d++) begin
      adj[4*d +: 4] = (dig_q[4*d +: 4] > 4'd4) ? dig_q[4*d +: 4] + 4'd3 : dig_q[4*d +: 4];
    end
    dig_step = {adj[BCD_W-2:0], op_q[OP_W-1]};
    op_step  = {op_q[OP_W-2:0], 1'b0};
  end

  always_comb begin : next_state
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    op_d      = op_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    grant_c   = '0;

    case (state_q)
      S_IDLE: begin
        out_bcd_d = '0;
        if (win_found) begin
          grant_c = N_REQ'(1) << win_id;
          last_d  = win_id;
          id_d    = win_id;
          op_d    = bus.req_data[{win_id, 3'b000} +: OP_W];
          dig_d   = '0;
          cnt_d   = CNT_W'(OP_W);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        dig_d = dig_step;
        op_d  = op_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_DONE;
          out_bcd_d = dig_step;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d   = S_IDLE;
          out_bcd_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        out_bcd_d = '0;
      end
    endcase

    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      dig_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Grant is the same-cycle acknowledge of the operand capture; suppressed while in reset.
  assign bus.grant     = rst_n ? grant_c : '0;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = id_q;
  assign bus.out_bcd   = out_bcd_q;

endmodule
